// File: rtl/mux2_n_to_n_pkg.sv
// Shared defaults for the two-input word selector and its optional output register.
package mux2_n_to_n_pkg;

  localparam int N_DEFAULT       = 32;
  localparam int REG_OUT_DEFAULT = 1;

endpackage

// File: rtl/mux2_comb.sv
// Purely combinational 2:1 word selector; an unknown select propagates as X in simulation.
module mux2_comb #(
  parameter int N = 32
) (
  input  logic [N-1:0] zero_src_i,
  input  logic [N-1:0] one_src_i,
  input  logic         sel_i,
  output logic [N-1:0] out_o
);

  // The default arm yields X for an X/Z select and is a don't-care for synthesis.
  always_comb begin
    out_o = zero_src_i;
    case (sel_i)
      1'b0:    out_o = zero_src_i;
      1'b1:    out_o = one_src_i;
      default: out_o = 'x;
    endcase
  end

endmodule

// File: rtl/mux2_n_to_n.sv
// N-bit 2:1 mux with an optional one-cycle registered copy and a post-reset valid flag.
module mux2_n_to_n
  import mux2_n_to_n_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int REG_OUT = REG_OUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] zeroSource,
  input  logic [N-1:0] oneSource,
  input  logic         select,
  output logic [N-1:0] out,
  output logic [N-1:0] out_q,
  output logic         out_valid
);

  mux2_comb #(.N(N)) u_mux (
    .zero_src_i (zeroSource),
    .one_src_i  (oneSource),
    .sel_i      (select),
    .out_o      (out)
  );

  if (REG_OUT != 0) begin : g_reg
    logic [N-1:0] data_d, data_q;
    logic         vld_q;

    assign data_d = out;

    // Output register stage: one sample per edge, cleared by reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        vld_q  <= 1'b1;
      end
    end

    assign out_q     = data_q;
    assign out_valid = vld_q;
  end else begin : g_noreg
    assign out_q     = '0;
    assign out_valid = 1'b0;
  end

endmodule

// File: tb/tb_mux2_n_to_n.sv
// Directed bench for mux2_n_to_n at N=50 with a queue-based scoreboard for the registered path.
module tb_mux2_n_to_n;

  localparam int N = 50;

  typedef struct {
    logic [N-1:0] data;
    logic         vld;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] zeroSource = '0;
  logic [N-1:0] oneSource = '0;
  logic         select = 1'b0;
  logic [N-1:0] out;
  logic [N-1:0] out_q;
  logic         out_valid;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [N-1:0] ALL1;
  logic [N-1:0] BIGA;
  logic [N-1:0] BIGB;
  logic [N-1:0] TOP;

  mux2_n_to_n #(.N(N), .REG_OUT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .zeroSource (zeroSource),
    .oneSource  (oneSource),
    .select     (select),
    .out        (out),
    .out_q      (out_q),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational result, and queue the registered expectation.
  task automatic step(input logic r, input logic s, input logic [N-1:0] z,
                      input logic [N-1:0] o, input logic [N-1:0] want_out);
    exp_t e;
    @(negedge clk);
    reset = r;
    select = s;
    zeroSource = z;
    oneSource = o;
    #1;
    chk("out", out, want_out);
    e.data = r ? '0 : want_out;
    e.vld  = !r;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("out_q", out_q, mon_e.data);
      chk("out_valid", {{(N-1){1'b0}}, out_valid}, {{(N-1){1'b0}}, mon_e.vld});
    end
  end

  initial begin
    ALL1 = '1;
    BIGA = 50'h2_3456_789A_BCDE;
    BIGB = 50'h1_FEDC_BA98_7654;
    TOP  = '0;
    TOP[N-1] = 1'b1;

    // Reset held two cycles: out is live, register stays clear.
    step(1'b1, 1'b1, 50'd0, 50'd55, 50'd55);
    step(1'b1, 1'b1, 50'd0, 50'd55, 50'd55);
    step(1'b0, 1'b1, 50'd0, 50'd55, 50'd55);

    step(1'b0, 1'b0, 50'd5,   50'd0,  50'd5);
    step(1'b0, 1'b1, 50'd3,   50'd55, 50'd55);
    step(1'b0, 1'b0, 50'd354, 50'd55, 50'd354);

    // Boundary: all-ones versus zero with select toggling every cycle.
    for (int i = 0; i < 6; i++)
      step(1'b0, i[0], ALL1, 50'd0, i[0] ? 50'd0 : ALL1);

    // Select and both sources change on the same cycle.
    step(1'b0, 1'b1, BIGA, BIGB, BIGB);
    step(1'b0, 1'b0, BIGB, BIGA, BIGB);
    step(1'b0, 1'b1, 50'd1, TOP, TOP);

    // Single-cycle reset mid-stream, then capture resumes.
    step(1'b0, 1'b0, 50'd7, 50'd8, 50'd7);
    step(1'b1, 1'b1, 50'd7, 50'd8, 50'd8);
    step(1'b0, 1'b0, 50'd9, 50'd8, 50'd9);
    step(1'b0, 1'b1, 50'd9, ALL1, ALL1);

    @(posedge clk);
    #2;
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
